mp3_vol_sci_writer: RTL

MP3_VOL_SCI_WRITER -- requirements
Module: mp3_vol_sci_writer

---
 rtl/mp3_pkg.sv | 20 ++
 rtl/mp3_vol_sci_writer_sync2.sv | 22 ++
 rtl/mp3_vol_sci_writer.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/mp3_pkg.sv
// Shared VS1003 constants and the SCI volume writer state type.
package mp3_pkg;

   localparam logic [7:0]  SCI_OP_WRITE = 8'h02;
   localparam logic [7:0]  SCI_ADDR_VOL = 8'h0B;

   // Volume presets shared with the volume-control block (0x00 = loudest).
   localparam logic [15:0] VOL_MAX      = 16'h0000;
   localparam logic [15:0] VOL_DEFAULT  = 16'h197F;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_DREQ,
      CS_SETUP,
      SHIFT,
      CS_HOLD,
      GAP
   } wr_state_t;

endpackage

// File: rtl/mp3_vol_sci_writer_sync2.sv
// Two-flop synchronizer for asynchronous VS1003 status inputs.
module sync2 (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   // Shift the asynchronous input through two flops.
   always_ff @(posedge clk) begin
      if (reset) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/mp3_vol_sci_writer.sv
// Writes SCI_VOL to a VS1003 over SCI whenever vol differs from the last value written.
module mp3_vol_sci_writer
   import mp3_pkg::*;
#(
   parameter int unsigned CLK_DIV = 50
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] vol,
   input  logic        dreq,
   output logic        xcs,
   output logic        xdcs,
   output logic        sck,
   output logic        mosi,
   output logic        busy,
   output logic        done
);

   localparam int unsigned HW    = $clog2(CLK_DIV);
   localparam logic [HW-1:0] HLAST = HW'(CLK_DIV - 1);

   wr_state_t     state, state_n;
   logic [HW-1:0] hcnt, hcnt_n;
   logic [4:0]    bitcnt, bitcnt_n;
   logic          sck_r, sck_n;
   logic [31:0]   frame, frame_n;
   logic [15:0]   data, data_n;
   logic [15:0]   shadow, shadow_n;
   logic          valid, valid_n;
   logic          dreq_s;
   logic          req;
   logic          hlast;

   sync2 u_sync_dreq (
      .clk   (clk),
      .reset (reset),
      .d     (dreq),
      .q     (dreq_s)
   );

   assign req   = !valid || (shadow != vol);
   assign hlast = (hcnt == HLAST);

   assign sck  = sck_r;
   assign mosi = frame[31];
   assign xcs  = !(state inside {CS_SETUP, SHIFT, CS_HOLD});
   assign xdcs = 1'b1;
   assign done = (state == GAP) && hlast;
   assign busy = !reset && ((state != IDLE) || req);

   // State, counters, shift register and shadow registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         hcnt   <= '0;
         bitcnt <= '0;
         sck_r  <= 1'b0;
         frame  <= '0;
         data   <= '0;
         shadow <= '0;
         valid  <= 1'b0;
      end else begin
         state  <= state_n;
         hcnt   <= hcnt_n;
         bitcnt <= bitcnt_n;
         sck_r  <= sck_n;
         frame  <= frame_n;
         data   <= data_n;
         shadow <= shadow_n;
         valid  <= valid_n;
      end
   end

   // Next-state logic; the frame shifts left (zero fill) on each sck fall so mosi idles at 0.
   always_comb begin
      state_n  = state;
      hcnt_n   = hcnt;
      bitcnt_n = bitcnt;
      sck_n    = sck_r;
      frame_n  = frame;
      data_n   = data;
      shadow_n = shadow;
      valid_n  = valid;
      unique case (state)
         IDLE: begin
            if (req) state_n = WAIT_DREQ;
         end
         WAIT_DREQ: begin
            if (dreq_s) begin
               frame_n = {SCI_OP_WRITE, SCI_ADDR_VOL, vol};
               data_n  = vol;
               hcnt_n  = '0;
               state_n = CS_SETUP;
            end
         end
         CS_SETUP: begin
            if (hlast) begin
               hcnt_n   = '0;
               bitcnt_n = '0;
               state_n  = SHIFT;
            end else begin
               hcnt_n = hcnt + 1'b1;
            end
         end
         SHIFT: begin
            if (hlast) begin
               hcnt_n = '0;
               if (!sck_r) begin
                  sck_n = 1'b1;
               end else begin
                  sck_n   = 1'b0;
                  frame_n = {frame[30:0], 1'b0};
                  if (bitcnt == 5'd31) state_n  = CS_HOLD;
                  else                 bitcnt_n = bitcnt + 5'd1;
               end
            end else begin
               hcnt_n = hcnt + 1'b1;
            end
         end
         CS_HOLD: begin
            if (hlast) begin
               hcnt_n   = '0;
               shadow_n = data;
               valid_n  = 1'b1;
               state_n  = GAP;
            end else begin
               hcnt_n = hcnt + 1'b1;
            end
         end
         GAP: begin
            if (hlast) begin
               hcnt_n  = '0;
               state_n = IDLE;
            end else begin
               hcnt_n = hcnt + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule
